// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, load/store size encodings
// and the MEM/WB pipeline payload.
package mem_stage_pkg;

    localparam int unsigned INST_SZ_DEF  = 32;
    localparam int unsigned MEM_ADDR_DEF = 8;
    localparam int unsigned BHW_SZ_DEF   = 3;
    localparam int unsigned REG_IDX_SZ   = 5;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b011;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic [INST_SZ_DEF-1:0] read_data;
        logic [INST_SZ_DEF-1:0] alu_result;
        logic [REG_IDX_SZ-1:0]  instr_rd;
        logic                   reg_write;
        logic                   mem_to_reg;
    } memwb_t;

    // Size from the low two bits; bit 2 only selects zero extension on loads.
    function automatic size_e bhw_size(input logic [2:0] bhw);
        case (bhw[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM -> MEM/WB pipeline bus; slave is the MEM stage, master the surrounding pipeline.
interface mem_stage_if #(
    parameter int unsigned INST_SZ = mem_stage_pkg::INST_SZ_DEF,
    parameter int unsigned BHW_SZ  = mem_stage_pkg::BHW_SZ_DEF
);
    logic [INST_SZ-1:0]                 i_alu_result_M;
    logic [INST_SZ-1:0]                 i_operand_b_M;
    logic [mem_stage_pkg::REG_IDX_SZ-1:0] i_instr_rd_M;
    logic                               i_mem_read_MC;
    logic                               i_mem_write_MC;
    logic                               i_reg_write_MC;
    logic                               i_mem_to_reg_MC;
    logic [BHW_SZ-1:0]                  i_bhw_MC;

    logic [INST_SZ-1:0]                 o_read_data_W;
    logic [INST_SZ-1:0]                 o_alu_result_W;
    logic [mem_stage_pkg::REG_IDX_SZ-1:0] o_instr_rd_W;
    logic                               o_reg_write_W;
    logic                               o_mem_to_reg_W;

    modport slave (
        input  i_alu_result_M, i_operand_b_M, i_instr_rd_M, i_mem_read_MC,
               i_mem_write_MC, i_reg_write_MC, i_mem_to_reg_MC, i_bhw_MC,
        output o_read_data_W, o_alu_result_W, o_instr_rd_W, o_reg_write_W, o_mem_to_reg_W
    );

    modport master (
        output i_alu_result_M, i_operand_b_M, i_instr_rd_M, i_mem_read_MC,
               i_mem_write_MC, i_reg_write_MC, i_mem_to_reg_MC, i_bhw_MC,
        input  o_read_data_W, o_alu_result_W, o_instr_rd_W, o_reg_write_W, o_mem_to_reg_W
    );
endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory with per-byte write enables, synchronous write/clear
// and two asynchronous read ports (datapath and debug).
module mem_stage_data_memory #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata,
    input  logic [ADDR_W-1:0]   i_dbg_addr,
    output logic [DATA_W-1:0]   o_dbg_data
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (i_be[k]) r_mem[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
            end
        end
    end

    assign o_rdata    = r_mem[i_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte-lane load/store into the data memory with alignment checking,
// followed by the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned INST_SZ  = INST_SZ_DEF,
    parameter int unsigned MEM_ADDR = MEM_ADDR_DEF,
    parameter int unsigned BHW_SZ   = BHW_SZ_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic [MEM_ADDR-1:0] i_debug_addr,
    output logic [INST_SZ-1:0]  o_debug_data,
    output logic                o_addr_err,
    mem_stage_if.slave          bus
);
    localparam int unsigned LANES = INST_SZ / 8;

    logic [BHW_SZ-1:0]   w_bhw;
    logic [MEM_ADDR-1:0] w_word_addr;
    logic [1:0]          w_lane;
    size_e               w_size;
    logic                w_misaligned;
    logic                w_fault;
    logic                w_store;
    logic [LANES-1:0]    w_be;
    logic [INST_SZ-1:0]  w_wdata;
    logic [INST_SZ-1:0]  w_rword;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [INST_SZ-1:0]  w_load;

    memwb_t r_wb;
    logic   r_addr_err;

    assign w_bhw       = bus.i_bhw_MC;
    assign w_word_addr = bus.i_alu_result_M[MEM_ADDR+1:2];
    assign w_lane      = bus.i_alu_result_M[1:0];

    // Alignment check and store lane/data steering.
    always_comb begin
        w_size       = bhw_size(3'(w_bhw));
        w_misaligned = ((w_size == SZ_HALF) && w_lane[0]) ||
                       ((w_size == SZ_WORD) && (w_lane != 2'b00));
        w_fault      = (bus.i_mem_read_MC | bus.i_mem_write_MC) & w_misaligned;
        w_store      = bus.i_mem_write_MC & ~w_misaligned & ~i_stall;
        w_be         = '1;
        w_wdata      = bus.i_operand_b_M;
        case (w_size)
            SZ_BYTE: begin
                w_be    = LANES'(1) << w_lane;
                w_wdata = {LANES{bus.i_operand_b_M[7:0]}};
            end
            SZ_HALF: begin
                w_be    = LANES'(3) << {w_lane[1], 1'b0};
                w_wdata = {(LANES/2){bus.i_operand_b_M[15:0]}};
            end
            default: ;
        endcase
        if (!w_store) w_be = '0;
    end

    // Load lane select and sign/zero extension; reads see the pre-store word.
    always_comb begin
        w_byte = 8'(w_rword >> {w_lane, 3'b000});
        w_half = 16'(w_rword >> {w_lane[1], 4'b0000});
        case (w_size)
            SZ_BYTE: w_load = {{(INST_SZ-8){w_byte[7] & ~w_bhw[2]}}, w_byte};
            SZ_HALF: w_load = {{(INST_SZ-16){w_half[15] & ~w_bhw[2]}}, w_half};
            default: w_load = w_rword;
        endcase
        if (!bus.i_mem_read_MC || w_misaligned) w_load = '0;
    end

    mem_stage_data_memory #(
        .DATA_W (INST_SZ),
        .ADDR_W (MEM_ADDR)
    ) u_dmem (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_be       (w_be),
        .i_addr     (w_word_addr),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rword),
        .i_dbg_addr (i_debug_addr),
        .o_dbg_data (o_debug_data)
    );

    // MEM/WB register and sticky alignment flag; both frozen while stalled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb       <= '0;
            r_addr_err <= 1'b0;
        end else if (!i_stall) begin
            r_wb.read_data  <= w_load;
            r_wb.alu_result <= bus.i_alu_result_M;
            r_wb.instr_rd   <= bus.i_instr_rd_M;
            r_wb.reg_write  <= bus.i_reg_write_MC;
            r_wb.mem_to_reg <= bus.i_mem_to_reg_MC;
            r_addr_err      <= r_addr_err | w_fault;
        end
    end

    assign bus.o_read_data_W  = r_wb.read_data;
    assign bus.o_alu_result_W = r_wb.alu_result;
    assign bus.o_instr_rd_W   = r_wb.instr_rd;
    assign bus.o_reg_write_W  = r_wb.reg_write;
    assign bus.o_mem_to_reg_W = r_wb.mem_to_reg;
    assign o_addr_err         = r_addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [7:0] dbg_addr;
    logic [31:0] dbg_data;
    logic       addr_err;

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_stall      (stall),
        .i_debug_addr (dbg_addr),
        .o_debug_data (dbg_data),
        .o_addr_err   (addr_err),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_mem [1024];
    logic [31:0] e_read, e_alu;
    logic [4:0]  e_rd;
    logic        e_rw, e_m2r, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] bhw);
        if (bhw[1:0] == 2'b00) return 1;
        if (bhw[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_word(input int widx);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w |= 32'(m_mem[4*widx + k]) << (8*k);
        return w;
    endfunction

    // One pipeline cycle: drive, clock, advance the model, compare everything.
    task automatic step(input logic r, input logic stl, input logic rd, input logic wr,
                        input logic rw, input logic m2r, input logic [2:0] bhw,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rdi, input logic [7:0] dbg);
        int n;
        int a;
        bit mis;
        logic [31:0] ld;
        rst = r; stall = stl; dbg_addr = dbg;
        bus.i_alu_result_M = addr; bus.i_operand_b_M = data; bus.i_instr_rd_M = rdi;
        bus.i_mem_read_MC = rd; bus.i_mem_write_MC = wr;
        bus.i_reg_write_MC = rw; bus.i_mem_to_reg_MC = m2r; bus.i_bhw_MC = bhw;
        n = nbytes(bhw);
        a = int'(addr[9:0]);
        mis = (a % n) != 0;
        ld = '0;
        if (rd && !mis) begin
            for (int k = 0; k < n; k++) ld |= 32'(m_mem[a + k]) << (8*k);
            if (!bhw[2] && n == 1 && ld[7])  ld |= 32'hFFFF_FF00;
            if (!bhw[2] && n == 2 && ld[15]) ld |= 32'hFFFF_0000;
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
            e_read = '0; e_alu = '0; e_rd = '0; e_rw = 1'b0; e_m2r = 1'b0; e_err = 1'b0;
        end else if (!stl) begin
            if (wr && !mis) for (int k = 0; k < n; k++) m_mem[a + k] = data[8*k +: 8];
            e_read = ld; e_alu = addr; e_rd = rdi; e_rw = rw; e_m2r = m2r;
            e_err = e_err | ((rd | wr) & mis);
        end
        check("read_data",  bus.o_read_data_W,        e_read);
        check("alu_result", bus.o_alu_result_W,       e_alu);
        check("instr_rd",   32'(bus.o_instr_rd_W),    32'(e_rd));
        check("reg_write",  32'(bus.o_reg_write_W),   32'(e_rw));
        check("mem_to_reg", 32'(bus.o_mem_to_reg_W),  32'(e_m2r));
        check("addr_err",   32'(addr_err),            32'(e_err));
        check("debug_data", dbg_data,                 m_word(int'(dbg)));
    endtask

    initial begin
        logic [2:0]  rb;
        logic [31:0] ra;
        int          rn;
        e_err = 1'b0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;

        step(1, 0, 0, 0, 0, 0, BHW_W, 32'h0, 32'h0, 5'd0, 8'd0);
        check("reset_rd", bus.o_read_data_W, 32'h0);

        // Word store then load, visible on debug port.
        step(0, 0, 0, 1, 0, 0, BHW_W, 32'h10, 32'hDEAD_BEEF, 5'd1, 8'd4);
        check("sw_dbg", dbg_data, 32'hDEAD_BEEF);
        step(0, 0, 1, 0, 1, 1, BHW_W, 32'h10, 32'h0, 5'd2, 8'd4);
        check("lw_data", bus.o_read_data_W, 32'hDEAD_BEEF);

        // Byte store and signed/unsigned byte loads.
        step(0, 0, 0, 1, 0, 0, BHW_W, 32'h10, 32'h0, 5'd0, 8'd4);
        step(0, 0, 0, 1, 0, 0, BHW_B, 32'h11, 32'h0000_0080, 5'd0, 8'd4);
        check("sb_word", dbg_data, 32'h0000_8000);
        step(0, 0, 1, 0, 1, 1, BHW_B, 32'h11, 32'h0, 5'd3, 8'd4);
        check("lb", bus.o_read_data_W, 32'hFFFF_FF80);
        step(0, 0, 1, 0, 1, 1, BHW_BU, 32'h11, 32'h0, 5'd3, 8'd4);
        check("lbu", bus.o_read_data_W, 32'h0000_0080);

        // Half store, half loads, misaligned half load.
        step(0, 0, 0, 1, 0, 0, BHW_H, 32'h12, 32'h0000_8001, 5'd0, 8'd4);
        step(0, 0, 1, 0, 1, 1, BHW_H, 32'h12, 32'h0, 5'd4, 8'd4);
        check("lh", bus.o_read_data_W, 32'hFFFF_8001);
        step(0, 0, 1, 0, 1, 1, BHW_HU, 32'h12, 32'h0, 5'd4, 8'd4);
        check("lhu", bus.o_read_data_W, 32'h0000_8001);
        step(0, 0, 1, 0, 1, 1, BHW_H, 32'h13, 32'h0, 5'd4, 8'd4);
        check("lh_mis_err", 32'(addr_err), 32'h1);
        check("lh_mis_mem", dbg_data, 32'h8001_8000);

        // Stalled store is dropped; released store commits.
        step(0, 1, 0, 1, 0, 0, BHW_W, 32'h20, 32'h1234_5678, 5'd5, 8'd8);
        check("stall_mem", dbg_data, 32'h0);
        step(0, 0, 0, 1, 0, 0, BHW_W, 32'h20, 32'h1234_5678, 5'd5, 8'd8);
        check("unstall_mem", dbg_data, 32'h1234_5678);

        // ALU pass-through.
        step(0, 0, 0, 0, 1, 0, BHW_W, 32'h42, 32'hFFFF_FFFF, 5'd7, 8'd8);
        check("pass_alu", bus.o_alu_result_W, 32'h42);

        // Reset beats a concurrent store.
        step(1, 0, 0, 1, 1, 0, BHW_W, 32'h0, 32'hCAFE_F00D, 5'd9, 8'd0);
        check("rst_err", 32'(addr_err), 32'h0);
        step(0, 0, 0, 0, 0, 0, BHW_W, 32'h0, 32'h0, 5'd0, 8'd8);
        check("rst_mem", dbg_data, 32'h0);

        // Random traffic in a small window so loads hit earlier stores.
        for (int t = 0; t < 600; t++) begin
            rb = 3'($urandom_range(0, 7));
            rn = nbytes(rb);
            ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) != 0) ra = ra & ~32'(rn - 1);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rb, ra, $urandom,
                 5'($urandom), 8'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
